// File: rtl/vc_out_arb_mux.sv
// Round-robin virtual-channel output mux with head-to-tail grant locking and a registered valid/ready output.
// Optional VC_MUX_SEL_OVERRIDE_EN adds a one-hot mux_sel input that replaces the round-robin choice in IDLE.
module vc_out_arb_mux #(
    parameter int DW     = 32,
    parameter int NUM_VC = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_VC*DW-1:0] data_in,
    input  logic [NUM_VC-1:0]    valid_in,
    input  logic [NUM_VC-1:0]    tail_in,
    output logic [NUM_VC-1:0]    ready_out,
    output logic [DW-1:0]        data_out,
    output logic                 valid_out,
    output logic                 tail_out,
    output logic [NUM_VC-1:0]    sel_out,
    input  logic                 ready_in
`ifdef VC_MUX_SEL_OVERRIDE_EN
    ,
    input  logic [NUM_VC-1:0]    mux_sel
`endif
);

    localparam int IW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [IW-1:0]       lock_vc_q;
    logic [DW-1:0]       data_q;
    logic                valid_q;
    logic                tail_q;
    logic [NUM_VC-1:0]   sel_q;

    logic [NUM_VC-1:0]   idle_oh;
    logic [NUM_VC-1:0]   lock_oh;
    logic [NUM_VC-1:0]   grant_oh;
    logic [IW-1:0]       grant_idx;
    logic [DW-1:0]       data_d;
    logic                tail_d;
    logic                load;
    logic                xfer;

`ifdef VC_MUX_SEL_OVERRIDE_EN
    always_comb begin
        idle_oh = $onehot(mux_sel) ? mux_sel : '0;
    end
`else
    logic rr_found;

    // Circular search from rr_ptr+1: first pass covers VCs above the pointer, second wraps to the rest.
    always_comb begin
        idle_oh  = '0;
        rr_found = 1'b0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (!rr_found && valid_in[i] && (i > 32'(rr_ptr_q))) begin
                idle_oh[i] = 1'b1;
                rr_found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (!rr_found && valid_in[i] && (i <= 32'(rr_ptr_q))) begin
                idle_oh[i] = 1'b1;
                rr_found   = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        lock_oh = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            lock_oh[i] = (32'(lock_vc_q) == i);
        end
    end

    always_comb begin
        grant_oh = (state_q == LOCKED) ? lock_oh : idle_oh;
    end

    always_comb begin
        grant_idx = '0;
        data_d    = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (grant_oh[i]) begin
                grant_idx = IW'(i);
                data_d    = data_in[i*DW +: DW];
            end
        end
    end

    always_comb begin
        load      = !valid_q || ready_in;
        ready_out = load ? grant_oh : '0;
        xfer      = |(valid_in & ready_out);
        tail_d    = |(tail_in & grant_oh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IW'(NUM_VC - 1);
            lock_vc_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            tail_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            if (xfer) begin
                data_q  <= data_d;
                tail_q  <= tail_d;
                sel_q   <= grant_oh;
                valid_q <= 1'b1;
            end else if (ready_in) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        rr_ptr_q <= grant_idx;
                        if (!tail_d) begin
                            state_q   <= LOCKED;
                            lock_vc_q <= grant_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && tail_d) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign tail_out  = tail_q;
    assign sel_out   = sel_q;

endmodule

// File: tb/tb_vc_out_arb_mux.sv
// Self-checking bench for vc_out_arb_mux: directed vector table, hand sequences, and randomized traffic vs. a behavioural model.
module tb_vc_out_arb_mux;

    localparam int DW = 32;
    localparam int NV = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     vc_data [NV];
    logic [NV*DW-1:0]  data_in;
    logic [NV-1:0]     valid_in;
    logic [NV-1:0]     tail_in;
    logic [NV-1:0]     ready_out;
    logic [DW-1:0]     data_out;
    logic              valid_out;
    logic              tail_out;
    logic [NV-1:0]     sel_out;
    logic              ready_in;
`ifdef VC_MUX_SEL_OVERRIDE_EN
    logic [NV-1:0]     mux_sel;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NV; g++) begin : g_pack
        assign data_in[g*DW +: DW] = vc_data[g];
    end

    vc_out_arb_mux #(.DW(DW), .NUM_VC(NV)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .tail_in   (tail_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .tail_out  (tail_out),
        .sel_out   (sel_out),
        .ready_in  (ready_in)
`ifdef VC_MUX_SEL_OVERRIDE_EN
        ,
        .mux_sel   (mux_sel)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: packet lock, round-robin pointer, output register.
    bit            m_locked;
    int            m_lock;
    int            m_ptr;
    logic          m_vout;
    logic          m_tail;
    logic [DW-1:0] m_data;
    logic [NV-1:0] m_sel;
    logic [NV-1:0] smp_ready;

    typedef struct {
        logic [NV-1:0] v;
        logic [NV-1:0] t;
        logic          r;
        logic [NV-1:0] er;
        logic          ev;
        int            vc;
        logic          et;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    task automatic m_reset();
        m_locked = 1'b0;
        m_lock   = 0;
        m_ptr    = NV - 1;
        m_vout   = 1'b0;
        m_tail   = 1'b0;
        m_data   = '0;
        m_sel    = '0;
    endtask

    function automatic int m_grant();
        if (m_locked) return m_lock;
`ifdef VC_MUX_SEL_OVERRIDE_EN
        if ($countones(mux_sel) != 1) return -1;
        for (int i = 0; i < NV; i++) if (mux_sel[i]) return i;
        return -1;
`else
        for (int k = 1; k <= NV; k++) begin
            int c;
            c = (m_ptr + k) % NV;
            if (valid_in[c]) return c;
        end
        return -1;
`endif
    endfunction

    // Called just after a rising edge with inputs already driven; checks one full cycle.
    task automatic tick(input string tag);
        int            g;
        logic          ld;
        logic [NV-1:0] er;
        #2;
        g  = m_grant();
        ld = !m_vout || ready_in;
        er = '0;
        if (g >= 0 && ld) er[g] = 1'b1;
        smp_ready = ready_out;
        check({tag, " ready_out"}, 64'(ready_out), 64'(er));
        if (g >= 0 && ld && valid_in[g]) begin
            m_vout = 1'b1;
            m_data = vc_data[g];
            m_tail = tail_in[g];
            m_sel  = '0;
            m_sel[g] = 1'b1;
            if (!m_locked) begin
                m_ptr = g;
                if (!tail_in[g]) begin
                    m_locked = 1'b1;
                    m_lock   = g;
                end
            end else if (tail_in[g]) begin
                m_locked = 1'b0;
            end
        end else if (ready_in) begin
            m_vout = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, " valid_out"}, 64'(valid_out), 64'(m_vout));
        check({tag, " data_out"},  64'(data_out),  64'(m_data));
        check({tag, " tail_out"},  64'(tail_out),  64'(m_tail));
        check({tag, " sel_out"},   64'(sel_out),   64'(m_sel));
    endtask

    task automatic drive(input logic [NV-1:0] v, input logic [NV-1:0] t, input logic r);
        valid_in = v;
        tail_in  = t;
        ready_in = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive('0, '0, 1'b0);
        for (int i = 0; i < NV; i++) vc_data[i] = pat(i);
`ifdef VC_MUX_SEL_OVERRIDE_EN
        mux_sel = '0;
`endif
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_out", 64'(valid_out), 64'(0));
        check("reset data_out",  64'(data_out),  64'(0));
        check("reset tail_out",  64'(tail_out),  64'(0));
        check("reset sel_out",   64'(sel_out),   64'(0));
        rst = 1'b0;

`ifndef VC_MUX_SEL_OVERRIDE_EN
        tbl[0]  = '{5'b00101, 5'b11111, 1'b1, 5'b00001, 1'b1, 0, 1'b1};
        tbl[1]  = '{5'b00101, 5'b11111, 1'b1, 5'b00100, 1'b1, 2, 1'b1};
        tbl[2]  = '{5'b00101, 5'b11111, 1'b1, 5'b00001, 1'b1, 0, 1'b1};
        tbl[3]  = '{5'b00101, 5'b11111, 1'b1, 5'b00100, 1'b1, 2, 1'b1};
        tbl[4]  = '{5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1, 1'b0};
        tbl[5]  = '{5'b01010, 5'b01000, 1'b1, 5'b00010, 1'b1, 1, 1'b0};
        tbl[6]  = '{5'b01010, 5'b01010, 1'b1, 5'b00010, 1'b1, 1, 1'b1};
        tbl[7]  = '{5'b01000, 5'b01000, 1'b1, 5'b01000, 1'b1, 3, 1'b1};
        tbl[8]  = '{5'b00001, 5'b00001, 1'b0, 5'b00000, 1'b1, 3, 1'b1};
        tbl[9]  = '{5'b00001, 5'b00001, 1'b0, 5'b00000, 1'b1, 3, 1'b1};
        tbl[10] = '{5'b00001, 5'b00001, 1'b0, 5'b00000, 1'b1, 3, 1'b1};
        tbl[11] = '{5'b00001, 5'b00001, 1'b0, 5'b00000, 1'b1, 3, 1'b1};
        tbl[12] = '{5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 0, 1'b1};
        tbl[13] = '{5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 2, 1'b0};
        tbl[14] = '{5'b10000, 5'b10000, 1'b1, 5'b00100, 1'b0, 2, 1'b0};
        tbl[15] = '{5'b10000, 5'b10000, 1'b1, 5'b00100, 1'b0, 2, 1'b0};
        tbl[16] = '{5'b10100, 5'b10100, 1'b1, 5'b00100, 1'b1, 2, 1'b1};
        tbl[17] = '{5'b10000, 5'b10000, 1'b1, 5'b10000, 1'b1, 4, 1'b1};
        tbl[18] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 4, 1'b1};

        for (int i = 0; i < 19; i++) begin
            logic [NV-1:0] esel;
            esel = '0;
            esel[tbl[i].vc] = 1'b1;
            drive(tbl[i].v, tbl[i].t, tbl[i].r);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl_ready", i), 64'(smp_ready), 64'(tbl[i].er));
            check($sformatf("vec%0d tbl_valid", i), 64'(valid_out), 64'(tbl[i].ev));
            check($sformatf("vec%0d tbl_sel", i),   64'(sel_out),   64'(esel));
            check($sformatf("vec%0d tbl_tail", i),  64'(tail_out),  64'(tbl[i].et));
            check($sformatf("vec%0d tbl_data", i),  64'(data_out),  64'(pat(tbl[i].vc)));
        end

        // Asynchronous reset in the middle of a VC1 packet.
        drive(5'b00010, 5'b00000, 1'b1);
        tick("prerst");
        #2 rst = 1'b1;
        #1;
        check("async_rst valid_out", 64'(valid_out), 64'(0));
        check("async_rst sel_out",   64'(sel_out),   64'(0));
        check("async_rst data_out",  64'(data_out),  64'(0));
        m_reset();
        #2 rst = 1'b0;
        drive(5'b11111, 5'b11111, 1'b1);
        tick("postrst0");
        check("postrst vc0 first", 64'(smp_ready), 64'(5'b00001));
        tick("postrst1");
        check("postrst vc1 next", 64'(smp_ready), 64'(5'b00010));
`else
        drive(5'b11111, 5'b11111, 1'b1);
        mux_sel = 5'b00011;
        tick("ovr_multi");
        check("ovr_multi no_grant", 64'(smp_ready), 64'(0));
        check("ovr_multi no_valid", 64'(valid_out), 64'(0));
        mux_sel = 5'b01000;
        tick("ovr_vc3");
        check("ovr_vc3 ready", 64'(smp_ready), 64'(5'b01000));
        check("ovr_vc3 sel",   64'(sel_out),   64'(5'b01000));
        check("ovr_vc3 data",  64'(data_out),  64'(pat(3)));
        mux_sel = 5'b00010;
        drive(5'b11111, 5'b00000, 1'b1);
        tick("ovr_lock");
        check("ovr_lock sel", 64'(sel_out), 64'(5'b00010));
        mux_sel = 5'b10000;
        drive(5'b11111, 5'b11111, 1'b1);
        tick("ovr_locked");
        check("ovr_locked ignores mux_sel", 64'(smp_ready), 64'(5'b00010));
        tick("ovr_vc4");
        check("ovr_vc4 sel", 64'(sel_out), 64'(5'b10000));

        drive(5'b00100, 5'b00000, 1'b1);
        mux_sel = 5'b00100;
        tick("prerst");
        #2 rst = 1'b1;
        #1;
        check("async_rst valid_out", 64'(valid_out), 64'(0));
        check("async_rst sel_out",   64'(sel_out),   64'(0));
        m_reset();
        #2 rst = 1'b0;
        drive(5'b11111, 5'b11111, 1'b1);
        mux_sel = 5'b00001;
        tick("postrst0");
        check("postrst unlocked", 64'(smp_ready), 64'(5'b00001));
`endif

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NV; i++) vc_data[i] = $urandom;
            valid_in = NV'($urandom);
            tail_in  = NV'($urandom);
            ready_in = ($urandom_range(0, 3) != 0);
`ifdef VC_MUX_SEL_OVERRIDE_EN
            case ($urandom_range(0, 3))
                0:       mux_sel = '0;
                1:       mux_sel = NV'($urandom);
                default: mux_sel = NV'(1) << $urandom_range(0, NV - 1);
            endcase
`endif
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
